fml_arbiter4: RTL

- Shares the single FML 8x16 port of the SDRAM controller (hpdmc) between four bus masters, e.g. CPU, VGA, DMA and a spare.
- Round-robin arbitration: one master owns the slave per transaction.
- While a master owns the slave, the arbiter forwards its address, stb and we, routes the burst's write data and byte-selects to the slave, and returns ack to that master only.
- Sits between the master-side FML bridges and hpdmc; single clock domain.

---
 rtl/fml_pkg.sv | 26 ++
 rtl/fml_rr_pick.sv | 42 ++++
 rtl/fml_arbiter4.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fml_pkg.sv
// ---------------------------------------------------------------------------
// fml_pkg
// Shared constants and types for the FML 8x16 four-master arbiter.
//   FML_BURST_LEN : data beats per FML transaction
//   FML_DW        : data beat width in bits
//   FML_SELW      : byte-select width per beat
//   fml_midx_t    : master index (one of four masters)
//   arb_state_e   : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package fml_pkg;

    localparam int FML_BURST_LEN = 8;
    localparam int FML_DW        = 16;
    localparam int FML_SELW      = 2;
    localparam int FML_MIDX_W    = 2;
    localparam int FML_NMASTERS  = 4;

    typedef logic [FML_MIDX_W-1:0] fml_midx_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fml_rr_pick.sv
// ---------------------------------------------------------------------------
// fml_rr_pick
// Combinational 4-way round-robin picker. The winner is the first requesting
// master after `last` in circular order 0->1->2->3->0.
//   req    : in  [3:0] request vector, bit N = master N
//   last   : in  [1:0] master that won most recently
//   valid  : out       at least one request is present
//   winner : out [1:0] chosen master (only meaningful when valid)
// ---------------------------------------------------------------------------
module fml_rr_pick
    import fml_pkg::*;
(
    input  logic [3:0] req,
    input  fml_midx_t  last,
    output logic       valid,
    output fml_midx_t  winner
);

    // Candidate gi is the master gi+1 positions after last; the 2-bit add
    // wraps naturally, so candidate 3 is `last` itself (lowest priority).
    fml_midx_t  cand_idx [4];
    logic [3:0] cand_req;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last + fml_midx_t'(gi + 1);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from lowest priority to highest so the nearest candidate wins.
    always_comb begin
        valid  = |req;
        winner = last;
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[k]) begin
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fml_arbiter4.sv
// ---------------------------------------------------------------------------
// fml_arbiter4
// Shares one FML 8x16 slave port (hpdmc) between four masters using
// round-robin arbitration, one transaction per grant.
//   sys_clk, sys_rst       : clock, asynchronous active-high reset
//   mN_adr/stb/we (N=0..3) : master request side
//   mN_sel/dw              : master write beat byte-select and data
//   mN_ack                 : per-master acknowledge (owner only)
//   m_dr                   : read data broadcast to all masters (= s_dr)
//   s_adr/stb/we/sel/dw    : to hpdmc
//   s_ack, s_dr            : from hpdmc
// ---------------------------------------------------------------------------
module fml_arbiter4
    import fml_pkg::*;
#(
    parameter int fml_depth = 26,
    parameter int burst_len = FML_BURST_LEN
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    output logic                 m0_ack,
    input  logic [FML_SELW-1:0]  m0_sel,
    input  logic [FML_DW-1:0]    m0_dw,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    output logic                 m1_ack,
    input  logic [FML_SELW-1:0]  m1_sel,
    input  logic [FML_DW-1:0]    m1_dw,

    input  logic [fml_depth-1:0] m2_adr,
    input  logic                 m2_stb,
    input  logic                 m2_we,
    output logic                 m2_ack,
    input  logic [FML_SELW-1:0]  m2_sel,
    input  logic [FML_DW-1:0]    m2_dw,

    input  logic [fml_depth-1:0] m3_adr,
    input  logic                 m3_stb,
    input  logic                 m3_we,
    output logic                 m3_ack,
    input  logic [FML_SELW-1:0]  m3_sel,
    input  logic [FML_DW-1:0]    m3_dw,

    output logic [FML_DW-1:0]    m_dr,

    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    input  logic                 s_ack,
    output logic [FML_SELW-1:0]  s_sel,
    output logic [FML_DW-1:0]    s_dw,
    input  logic [FML_DW-1:0]    s_dr
);

    localparam int CNT_W = (burst_len > 1) ? $clog2(burst_len) : 1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(burst_len - 1);

    // Master-side signals gathered into arrays so the owner can index them.
    logic [fml_depth-1:0] mst_adr [4];
    logic [FML_SELW-1:0]  mst_sel [4];
    logic [FML_DW-1:0]    mst_dw  [4];
    logic [3:0]           mst_stb;
    logic [3:0]           mst_we;
    logic [3:0]           mst_ack;

    assign mst_adr[0] = m0_adr;  assign mst_adr[1] = m1_adr;
    assign mst_adr[2] = m2_adr;  assign mst_adr[3] = m3_adr;
    assign mst_sel[0] = m0_sel;  assign mst_sel[1] = m1_sel;
    assign mst_sel[2] = m2_sel;  assign mst_sel[3] = m3_sel;
    assign mst_dw[0]  = m0_dw;   assign mst_dw[1]  = m1_dw;
    assign mst_dw[2]  = m2_dw;   assign mst_dw[3]  = m3_dw;
    assign mst_stb    = {m3_stb, m2_stb, m1_stb, m0_stb};
    assign mst_we     = {m3_we,  m2_we,  m1_we,  m0_we};

    assign m0_ack = mst_ack[0];
    assign m1_ack = mst_ack[1];
    assign m2_ack = mst_ack[2];
    assign m3_ack = mst_ack[3];

    arb_state_e       state_q, state_d;
    fml_midx_t        owner_q, owner_d;
    fml_midx_t        rr_last_q, rr_last_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             wr_burst_q, wr_burst_d;

    logic      pick_valid;
    fml_midx_t pick_winner;

    fml_rr_pick u_pick (
        .req    (mst_stb),
        .last   (rr_last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    logic own_stb;
    logic own_we;
    logic in_req;
    logic in_wr_beat;

    assign own_stb    = mst_stb[owner_q];
    assign own_we     = mst_we[owner_q];
    assign in_req     = (state_q == ARB_REQ);
    assign in_wr_beat = (state_q == ARB_BURST) && wr_burst_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        beat_d     = beat_q;
        wr_burst_d = wr_burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d   = pick_winner;
                    rr_last_d = pick_winner;
                    state_d   = ARB_REQ;
                end
            end
            ARB_REQ: begin
                // A master withdrawing before ack abandons the grant.
                if (!own_stb) begin
                    state_d = ARB_IDLE;
                end else if (s_ack) begin
                    state_d    = ARB_BURST;
                    beat_d     = '0;
                    wr_burst_d = own_we;
                end
            end
            ARB_BURST: begin
                beat_d = beat_q + CNT_W'(1);
                if (beat_q == BEAT_LAST) begin
                    state_d = ARB_IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_last_q  <= fml_midx_t'(3);
            beat_q     <= '0;
            wr_burst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_q     <= beat_d;
            wr_burst_q <= wr_burst_d;
        end
    end

    // Slave-side outputs are decoded from the state so that an asynchronous
    // reset forces them to zero immediately.
    assign s_stb = in_req && own_stb;
    assign s_adr = in_req ? mst_adr[owner_q] : '0;
    assign s_we  = in_req && own_we;
    assign s_sel = in_wr_beat ? mst_sel[owner_q] : '0;
    assign s_dw  = in_wr_beat ? mst_dw[owner_q]  : '0;
    assign m_dr  = s_dr;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ack
            assign mst_ack[gi] = in_req && own_stb && s_ack
                                 && (owner_q == fml_midx_t'(gi));
        end
    endgenerate

endmodule
